// File: rtl/stack_return_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stack_return_sequencer_pkg
//
// Types and constants shared between the stack return sequencer and the rest of
// the 6502-style CPU slice:
//   - cpu_addr_t         : 16-bit address bus type (also used by the PC block)
//   - STACK_PAGE_DEFAULT : high address byte of the hardware stack page
//   - srs_state_e        : state encoding of the push/pull sequencer FSM
//   - stack_addr()       : forms a full stack address from page and SP byte
// -----------------------------------------------------------------------------
package stack_return_sequencer_pkg;

    // Address type shared with the program counter block.
    typedef logic [15:0] cpu_addr_t;

    // The 6502 hardware stack lives in page $01.
    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

    // Push/pull sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PUSH_H    = 4'd1,
        ST_PUSH_L    = 4'd2,
        ST_PUSH_P    = 4'd3,
        ST_PULL_P    = 4'd4,
        ST_PULL_L    = 4'd5,
        ST_PULL_H    = 4'd6,
        ST_PULL_WAIT = 4'd7,
        ST_FINISH    = 4'd8
    } srs_state_e;

    // Every stack access stays inside the stack page: the SP only ever
    // supplies the low byte.
    function automatic cpu_addr_t stack_addr(input logic [7:0] page,
                                             input logic [7:0] sp);
        return {page, sp};
    endfunction

endpackage : stack_return_sequencer_pkg

// File: rtl/stack_return_sequencer.sv
// -----------------------------------------------------------------------------
// stack_return_sequencer
//
// Stack-side counterpart of the program counter. Owns the 8-bit stack
// pointer, pushes PCH/PCL (and optionally P) for JSR/BRK/IRQ/NMI and pulls
// them back for RTS/RTI, handing the restored PC to the PC block through a
// one-cycle load pulse.
//
// Parameters
//   SP_RESET    stack pointer value after reset
//   STACK_PAGE  high address byte of every stack access
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   push_req, pull_req    start a push / pull sequence (sampled in IDLE only)
//   include_p             push/pull the status byte as well
//   rts_adjust            add 1 to the pulled PC (RTS)
//   pcl_in, pch_in, p_in  values to push
//   sp_in, sp_write       TXS: load SP (IDLE only, beats any request)
//   mem_rdata             read data, valid the cycle after mem_re
//   mem_addr, mem_wdata   stack address / write data
//   mem_we, mem_re        write / read strobes (never both)
//   pcl_out, pch_out      pulled PC (registered), pc_load one-cycle pulse
//   p_out, p_load         pulled status byte (registered), one-cycle pulse
//   sp_out                current stack pointer
//   busy, done            non-IDLE indicator, one-cycle completion pulse
// -----------------------------------------------------------------------------
module stack_return_sequencer
    import stack_return_sequencer_pkg::*;
#(
    parameter logic [7:0] SP_RESET   = 8'hFD,
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_req,
    input  logic        pull_req,
    input  logic        include_p,
    input  logic        rts_adjust,
    input  logic [7:0]  pcl_in,
    input  logic [7:0]  pch_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  sp_in,
    input  logic        sp_write,
    input  logic [7:0]  mem_rdata,
    output cpu_addr_t   mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  pcl_out,
    output logic [7:0]  pch_out,
    output logic        pc_load,
    output logic [7:0]  p_out,
    output logic        p_load,
    output logic [7:0]  sp_out,
    output logic        busy,
    output logic        done
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    srs_state_e  state_r;
    srs_state_e  state_s;

    logic [7:0]  sp_r;          // stack pointer
    logic [7:0]  pcl_lat_r;     // PCL captured at push request
    logic [7:0]  pch_lat_r;     // PCH captured at push request
    logic [7:0]  p_lat_r;       // P captured at push request
    logic        inc_p_r;       // sequence includes the status byte
    logic        adj_r;         // pulled PC gets +1 (RTS)
    logic        is_pull_r;     // current sequence is a pull
    logic [7:0]  pcl_pull_r;    // PCL read back, waiting for PCH
    logic [7:0]  pcl_out_r;
    logic [7:0]  pch_out_r;
    logic [7:0]  p_out_r;

    // 8-bit modulo arithmetic keeps every access inside the stack page.
    logic [7:0]  sp_inc_s;
    logic [7:0]  sp_dec_s;
    logic [15:0] pc_sum_s;

    assign sp_inc_s = sp_r + 8'd1;
    assign sp_dec_s = sp_r - 8'd1;
    // PCH arrives on mem_rdata in PULL_WAIT; the carry out of bit 15 is
    // dropped so $FFFF+1 wraps to $0000.
    assign pc_sum_s = {mem_rdata, pcl_pull_r} + {15'd0, adj_r};

    assign sp_out  = sp_r;
    assign pcl_out = pcl_out_r;
    assign pch_out = pch_out_r;
    assign p_out   = p_out_r;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                // TXS wins outright; push beats pull when both are raised.
                if (sp_write) begin
                    state_s = ST_IDLE;
                end else if (push_req) begin
                    state_s = ST_PUSH_H;
                end else if (pull_req) begin
                    if (include_p) begin
                        state_s = ST_PULL_P;
                    end else begin
                        state_s = ST_PULL_L;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PUSH_H: state_s = ST_PUSH_L;
            ST_PUSH_L: begin
                if (inc_p_r) begin
                    state_s = ST_PUSH_P;
                end else begin
                    state_s = ST_FINISH;
                end
            end
            ST_PUSH_P:    state_s = ST_FINISH;
            ST_PULL_P:    state_s = ST_PULL_L;
            ST_PULL_L:    state_s = ST_PULL_H;
            ST_PULL_H:    state_s = ST_PULL_WAIT;
            ST_PULL_WAIT: state_s = ST_FINISH;
            ST_FINISH:    state_s = ST_IDLE;
            default:      state_s = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM output decode (strobes and pulses follow the current state only)
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        pc_load   = 1'b0;
        p_load    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            // Pushes write at SP, then post-decrement.
            ST_PUSH_H: begin
                mem_addr  = stack_addr(STACK_PAGE, sp_r);
                mem_wdata = pch_lat_r;
                mem_we    = 1'b1;
            end
            ST_PUSH_L: begin
                mem_addr  = stack_addr(STACK_PAGE, sp_r);
                mem_wdata = pcl_lat_r;
                mem_we    = 1'b1;
            end
            ST_PUSH_P: begin
                mem_addr  = stack_addr(STACK_PAGE, sp_r);
                mem_wdata = p_lat_r;
                mem_we    = 1'b1;
            end
            // Pulls pre-increment: the read targets SP+1.
            ST_PULL_P, ST_PULL_L, ST_PULL_H: begin
                mem_addr = stack_addr(STACK_PAGE, sp_inc_s);
                mem_re   = 1'b1;
            end
            ST_PULL_WAIT: begin
                busy = 1'b1;
            end
            ST_FINISH: begin
                done    = 1'b1;
                pc_load = is_pull_r;
                p_load  = is_pull_r & inc_p_r;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: stack pointer, request latches and pulled-value capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_r       <= SP_RESET;
            pcl_lat_r  <= 8'h00;
            pch_lat_r  <= 8'h00;
            p_lat_r    <= 8'h00;
            inc_p_r    <= 1'b0;
            adj_r      <= 1'b0;
            is_pull_r  <= 1'b0;
            pcl_pull_r <= 8'h00;
            pcl_out_r  <= 8'h00;
            pch_out_r  <= 8'h00;
            p_out_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sp_write) begin
                        sp_r <= sp_in;
                    end else if (push_req) begin
                        pcl_lat_r <= pcl_in;
                        pch_lat_r <= pch_in;
                        p_lat_r   <= p_in;
                        inc_p_r   <= include_p;
                        adj_r     <= 1'b0;
                        is_pull_r <= 1'b0;
                    end else if (pull_req) begin
                        inc_p_r   <= include_p;
                        adj_r     <= rts_adjust;
                        is_pull_r <= 1'b1;
                    end else begin
                        sp_r <= sp_r;
                    end
                end
                ST_PUSH_H, ST_PUSH_L, ST_PUSH_P: begin
                    sp_r <= sp_dec_s;
                end
                ST_PULL_P: begin
                    sp_r <= sp_inc_s;
                end
                ST_PULL_L: begin
                    sp_r <= sp_inc_s;
                    // mem_rdata holds the P byte read in PULL_P.
                    if (inc_p_r) begin
                        p_out_r <= mem_rdata;
                    end else begin
                        p_out_r <= p_out_r;
                    end
                end
                ST_PULL_H: begin
                    sp_r       <= sp_inc_s;
                    pcl_pull_r <= mem_rdata;
                end
                ST_PULL_WAIT: begin
                    pch_out_r <= pc_sum_s[15:8];
                    pcl_out_r <= pc_sum_s[7:0];
                end
                ST_FINISH: begin
                    sp_r <= sp_r;
                end
                default: begin
                    sp_r <= sp_r;
                end
            endcase
        end
    end

endmodule : stack_return_sequencer

// File: tb/tb_stack_return_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_return_sequencer
//
// Self-checking bench. A transaction-level model turns each accepted request
// into the list of per-cycle outputs the sequencer must produce (which stack
// byte is written/read where, when done/pc_load/p_load pulse, the SP value),
// and a single compare process checks the DUT against that list every cycle.
// Directed scenarios pin the model with literal values; a randomized phase
// then exercises arbitration, ignored requests while busy and SP wrap.
// -----------------------------------------------------------------------------
module tb_stack_return_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        push_req, pull_req, include_p, rts_adjust, sp_write;
    logic [7:0]  pcl_in, pch_in, p_in, sp_in;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  pcl_out, pch_out, p_out, sp_out;
    logic        pc_load, p_load, busy, done;

    always #5 clk = ~clk;

    stack_return_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_req   (push_req),
        .pull_req   (pull_req),
        .include_p  (include_p),
        .rts_adjust (rts_adjust),
        .pcl_in     (pcl_in),
        .pch_in     (pch_in),
        .p_in       (p_in),
        .sp_in      (sp_in),
        .sp_write   (sp_write),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .pcl_out    (pcl_out),
        .pch_out    (pch_out),
        .pc_load    (pc_load),
        .p_out      (p_out),
        .p_load     (p_load),
        .sp_out     (sp_out),
        .busy       (busy),
        .done       (done)
    );

    // Stack page memory: synchronous write, read data registered one cycle.
    logic [7:0] mem [0:255];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom_range(0, 255));
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // ------------------------------------------------------------------
    // Model: expected outputs per cycle
    // ------------------------------------------------------------------
    typedef struct {
        bit         we, re, busy, done, pcl_ld, pl_ld;
        logic [15:0] addr;
        logic [7:0]  wdata, pcl, pch, p, sp;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cmp_e;
    logic [7:0] m_sp, m_pcl, m_pch, m_p;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         req_cyc = 0;
    int         last_lat = -1;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r.we = 1'b0; r.re = 1'b0; r.busy = 1'b0; r.done = 1'b0;
        r.pcl_ld = 1'b0; r.pl_ld = 1'b0;
        r.addr = 16'h0000; r.wdata = 8'h00;
        r.pcl = m_pcl; r.pch = m_pch; r.p = m_p; r.sp = m_sp;
        return r;
    endfunction

    // Push: PCH, PCL, [P] written at SP, SP-1, SP-2, then a done cycle.
    task automatic gen_push(input logic [7:0] pch, pcl, p, input bit inc);
        exp_t       r;
        logic [7:0] s;
        logic [7:0] vals [3];
        int         n;
        s = m_sp;
        vals[0] = pch; vals[1] = pcl; vals[2] = p;
        n = inc ? 3 : 2;
        for (int i = 0; i < n; i++) begin
            r = idle_rec();
            r.busy = 1'b1; r.we = 1'b1; r.addr = {8'h01, s}; r.wdata = vals[i]; r.sp = s;
            exp_q.push_back(r);
            s = s - 8'd1;
        end
        r = idle_rec();
        r.busy = 1'b1; r.done = 1'b1; r.sp = s;
        exp_q.push_back(r);
        m_sp = s;
    endtask

    // Pull: [P], PCL, PCH read from SP+1 upward, a wait cycle, then load.
    task automatic gen_pull(input bit inc, input bit adj);
        exp_t        r;
        logic [7:0]  s, a, pv, lo, hi;
        logic [15:0] pc;
        int          n;
        s  = m_sp;
        a  = s + 8'd1;
        pv = inc ? mem[a] : m_p;
        a  = s + 8'd1 + (inc ? 8'd1 : 8'd0);
        lo = mem[a];
        a  = a + 8'd1;
        hi = mem[a];
        pc = {hi, lo} + 16'(adj);
        n  = inc ? 3 : 2;
        for (int i = 0; i < n; i++) begin
            r = idle_rec();
            r.busy = 1'b1; r.re = 1'b1; r.addr = {8'h01, s + 8'd1}; r.sp = s;
            r.p = (inc && i == 2) ? pv : m_p;
            exp_q.push_back(r);
            s = s + 8'd1;
        end
        r = idle_rec();
        r.busy = 1'b1; r.sp = s; r.p = pv;
        exp_q.push_back(r);
        r = idle_rec();
        r.busy = 1'b1; r.done = 1'b1; r.pcl_ld = 1'b1; r.pl_ld = inc;
        r.sp = s; r.p = pv; r.pch = pc[15:8]; r.pcl = pc[7:0];
        exp_q.push_back(r);
        m_sp = s; m_p = pv; m_pch = pc[15:8]; m_pcl = pc[7:0];
    endtask

    // Drive inputs for the next edge and extend the model when the DUT
    // will sample them in IDLE.
    task automatic apply(input bit pu, pl, ip, adj, spw,
                         input logic [7:0] pcl, pch, p, spi);
        push_req = pu; pull_req = pl; include_p = ip; rts_adjust = adj;
        sp_write = spw; pcl_in = pcl; pch_in = pch; p_in = p; sp_in = spi;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL model_sync t=%0t got=0 expected=1", $time);
            exp_q.push_back(idle_rec());
        end else if (exp_q.size() == 1) begin
            if (exp_q[0].busy) begin
                exp_q.push_back(idle_rec());
            end else if (spw) begin
                m_sp = spi;
                exp_q.push_back(idle_rec());
            end else if (pu) begin
                gen_push(pch, pcl, p, ip);
                req_cyc = cyc;
            end else if (pl) begin
                gen_pull(ip, adj);
                req_cyc = cyc;
            end else begin
                exp_q.push_back(idle_rec());
            end
        end
    endtask

    task automatic tick(input bit pu, pl, ip, adj, spw,
                        input logic [7:0] pcl, pch, p, spi);
        @(posedge clk);
        #1;
        apply(pu, pl, ip, adj, spw, pcl, pch, p, spi);
    endtask

    task automatic settle();
        repeat (7) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_sp = 8'hFD; m_pcl = 8'h00; m_pch = 8'h00; m_p = 8'h00;
        exp_q.delete();
        exp_q.push_back(idle_rec());
        chk_en = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    // Compare process: one model record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                chk("model_underrun", 16'd0, 16'd1);
            end else begin
                cmp_e = exp_q.pop_front();
                chk("mem_we",  16'(mem_we),  16'(cmp_e.we));
                chk("mem_re",  16'(mem_re),  16'(cmp_e.re));
                if (cmp_e.we || cmp_e.re) chk("mem_addr", mem_addr, cmp_e.addr);
                if (cmp_e.we) chk("mem_wdata", 16'(mem_wdata), 16'(cmp_e.wdata));
                chk("busy",    16'(busy),    16'(cmp_e.busy));
                chk("done",    16'(done),    16'(cmp_e.done));
                chk("pc_load", 16'(pc_load), 16'(cmp_e.pcl_ld));
                chk("p_load",  16'(p_load),  16'(cmp_e.pl_ld));
                chk("sp_out",  16'(sp_out),  16'(cmp_e.sp));
                chk("pc_out",  {pch_out, pcl_out}, {cmp_e.pch, cmp_e.pcl});
                chk("p_out",   16'(p_out),   16'(cmp_e.p));
            end
            if (done === 1'b1) last_lat = cyc - req_cyc;
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset_n = 1'b0;
        push_req = 1'b0; pull_req = 1'b0; include_p = 1'b0; rts_adjust = 1'b0;
        sp_write = 1'b0; pcl_in = 8'h00; pch_in = 8'h00; p_in = 8'h00; sp_in = 8'h00;
        #7;
        chk("rst_sp",    16'(sp_out), 16'h00FD);
        chk("rst_busy",  16'(busy), 16'd0);
        chk("rst_strobe", {12'd0, mem_we, mem_re, done, pc_load}, 16'd0);
        chk("rst_pc",    {pch_out, pcl_out}, 16'h0000);
        chk("rst_p",     16'(p_out), 16'h0000);
        release_reset();

        // JSR push
        last_lat = -1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h34, 8'h12, 8'h00, 8'h00);
        settle();
        chk("jsr_mem_fd", 16'(mem[8'hFD]), 16'h0012);
        chk("jsr_mem_fc", 16'(mem[8'hFC]), 16'h0034);
        chk("jsr_sp", 16'(sp_out), 16'h00FB);
        chk("jsr_lat", 16'(last_lat), 16'd3);

        // RTS pull
        last_lat = -1;
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        settle();
        chk("rts_pc", {pch_out, pcl_out}, 16'h1235);
        chk("rts_sp", 16'(sp_out), 16'h00FD);
        chk("rts_lat", 16'(last_lat), 16'd4);

        // IRQ push with SP wrap
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01);
        settle();
        last_lat = -1;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hCD, 8'hAB, 8'hA5, 8'h00);
        settle();
        chk("irq_mem_01", 16'(mem[8'h01]), 16'h00AB);
        chk("irq_mem_00", 16'(mem[8'h00]), 16'h00CD);
        chk("irq_mem_ff", 16'(mem[8'hFF]), 16'h00A5);
        chk("irq_sp", 16'(sp_out), 16'h00FE);
        chk("irq_lat", 16'(last_lat), 16'd4);

        // RTI
        last_lat = -1;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        settle();
        chk("rti_p", 16'(p_out), 16'h00A5);
        chk("rti_pc", {pch_out, pcl_out}, 16'hABCD);
        chk("rti_sp", 16'(sp_out), 16'h0001);
        chk("rti_lat", 16'(last_lat), 16'd5);

        // RTS adjust wrap: stacked $FFFF + 1 -> $0000
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h3C, 8'h00);
        settle();
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        settle();
        chk("wrap_pc", {pch_out, pcl_out}, 16'h0000);
        chk("wrap_p", 16'(p_out), 16'h003C);

        // sp_write beats simultaneous push and pull
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h80);
        settle();
        chk("arb_sp", 16'(sp_out), 16'h0080);
        chk("arb_busy", 16'(busy), 16'd0);

        // push beats pull
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 8'h55, 8'h66, 8'h00);
        settle();
        chk("pushwin_sp", 16'(sp_out), 16'h007E);
        chk("pushwin_mem", 16'(mem[8'h80]), 16'h0055);

        // Randomized traffic, including requests raised while busy
        repeat (2000) begin
            tick(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        settle();

        // Abort: reset after the first push write
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 8'h55, 8'h00, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_we", 16'(mem_we), 16'd0);
        chk("abort_sp", 16'(sp_out), 16'h00FD);
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {13'd0, mem_we, mem_re, busy}, 16'd0);
        end
        release_reset();
        repeat (20) begin
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), 1'b0,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        settle();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stack_return_sequencer
